// File: rtl/soc_bus_fabric_pkg.sv
// Shared types and system address map for the FemtoRV32 bus fabric.
// The same constants are used by the fabric top and by the firmware.
package soc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } bus_state_e;

    localparam logic [31:0] MEM_BASE          = 32'h0000_0000;
    localparam logic [31:0] GPIO_BASE         = 32'h1000_0000;
    localparam logic [31:0] PERIPH0_BASE      = 32'h2000_0000;
    localparam logic [31:0] PERIPH1_BASE      = 32'h3000_0000;
    localparam logic [31:0] REGION_MASK       = 32'hF000_0000;
    localparam logic [31:0] BUS_DEFAULT_RDATA = 32'hDEAD_BEEF;

    localparam logic [127:0] DEFAULT_SLV_BASE = {PERIPH1_BASE, PERIPH0_BASE, GPIO_BASE, MEM_BASE};
    localparam logic [127:0] DEFAULT_SLV_MASK = {4{REGION_MASK}};

endpackage

// File: rtl/soc_bus_fabric_decoder.sv
// Combinational table-driven address decoder: lowest-index matching slave wins.
module bus_addr_decoder #(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned AW       = 32,
    parameter logic [N_SLAVES*AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*AW-1:0] SLV_MASK = '0,
    localparam int unsigned IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [AW-1:0]       addr_i,
    output logic [N_SLAVES-1:0] hit_o,
    output logic [IW-1:0]       idx_o,
    output logic                unmapped_o
);

    logic found;

    always_comb begin
        hit_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (!found && ((addr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                hit_o[i] = 1'b1;
                idx_o    = IW'(i);
                found    = 1'b1;
            end
        end
        unmapped_o = !found;
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// 1-master/N-slave fabric: latched request, registered response capture,
// wait states with per-access timeout, and sticky error capture.
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter logic [N_SLAVES*AW-1:0] SLV_BASE = DEFAULT_SLV_BASE,
    parameter logic [N_SLAVES*AW-1:0] SLV_MASK = DEFAULT_SLV_MASK,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0] DEFAULT_RDATA = BUS_DEFAULT_RDATA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          m_addr,
    input  logic [DW-1:0]          m_wdata,
    input  logic [DW/8-1:0]        m_wmask,
    input  logic                   m_rstrb,
    output logic [DW-1:0]          m_rdata,
    output logic                   m_rbusy,
    output logic                   m_wbusy,
    output logic [AW-1:0]          s_addr,
    output logic [DW-1:0]          s_wdata,
    output logic [DW/8-1:0]        s_wstrb,
    output logic [N_SLAVES-1:0]    s_ren,
    output logic [N_SLAVES-1:0]    s_wen,
    input  logic [N_SLAVES*DW-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]    s_rvalid,
    input  logic [N_SLAVES-1:0]    s_wready,
    input  logic                   err_clr,
    output logic                   err_irq,
    output logic [AW-1:0]          err_addr
);

    localparam int unsigned IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    bus_state_e          state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW/8-1:0]     wstrb_q, wstrb_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                unmapped_q, unmapped_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                err_irq_q, err_irq_d;
    logic [AW-1:0]       err_addr_q, err_addr_d;

    logic [N_SLAVES-1:0] dec_hit;
    logic [IW-1:0]       dec_idx;
    logic                dec_unmapped;

    logic                rsp_rd, rsp_wr, timeout_hit, err_set;
    logic [CW:0]         cnt_inc;
    logic [DW-1:0]       slv_rdata;

    bus_addr_decoder #(
        .N_SLAVES (N_SLAVES),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr_i     (m_addr),
        .hit_o      (dec_hit),
        .idx_o      (dec_idx),
        .unmapped_o (dec_unmapped)
    );

    // sel_q is zero for unmapped accesses, so strays from any slave are masked off
    assign rsp_rd      = |(s_rvalid & sel_q);
    assign rsp_wr      = |(s_wready & sel_q);
    assign slv_rdata   = s_rdata[idx_q*DW +: DW];
    assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
    assign timeout_hit = (cnt_inc >= (CW+1)'(TIMEOUT_CYCLES));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        unmapped_d = unmapped_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if ((|m_wmask) || m_rstrb) begin
                    addr_d     = m_addr;
                    wdata_d    = m_wdata;
                    wstrb_d    = m_wmask;
                    sel_d      = dec_hit;
                    idx_d      = dec_idx;
                    unmapped_d = dec_unmapped;
                    cnt_d      = '0;
                    state_d    = (|m_wmask) ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ, RD_WAIT: begin
                if (unmapped_q) begin
                    rdata_d = DEFAULT_RDATA;
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (rsp_rd) begin
                    rdata_d = slv_rdata;
                    state_d = IDLE;
                end else if (state_q == RD_REQ) begin
                    state_d = RD_WAIT;
                end else if (timeout_hit) begin
                    rdata_d = DEFAULT_RDATA;
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            WR_REQ, WR_WAIT: begin
                if (unmapped_q) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (rsp_wr) begin
                    state_d = IDLE;
                end else if (state_q == WR_REQ) begin
                    state_d = WR_WAIT;
                end else if (timeout_hit) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new error beats a simultaneous clear and re-arms the captured address
    always_comb begin
        err_irq_d  = err_irq_q;
        err_addr_d = err_addr_q;
        if (err_set) begin
            err_irq_d = 1'b1;
            if (!err_irq_q || err_clr) begin
                err_addr_d = addr_q;
            end
        end else if (err_clr) begin
            err_irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            sel_q      <= '0;
            idx_q      <= '0;
            unmapped_q <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            unmapped_q <= unmapped_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_irq_q  <= err_irq_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_rdata  = rdata_q;
    assign m_rbusy  = (state_q == RD_REQ) || (state_q == RD_WAIT);
    assign m_wbusy  = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;
    assign s_ren    = (state_q == RD_REQ) ? sel_q : '0;
    assign s_wen    = (state_q == WR_REQ) ? sel_q : '0;
    assign err_irq  = err_irq_q;
    assign err_addr = err_addr_q;

endmodule
